// File: rtl/imgproc_pkg.sv
// Shared image-processing defaults and the line-buffer FSM state encoding.
package imgproc_pkg;

  localparam int WIDTH_DEF      = 24;
  localparam int PIC_WIDTH_DEF  = 480;
  localparam int PIC_HEIGHT_DEF = 272;

  typedef enum logic [1:0] {
    FILL0 = 2'd0,
    FILL1 = 2'd1,
    RUN   = 2'd2
  } lb_state_e;

  // True while the window still lacks a full set of earlier rows.
  function automatic logic is_fill(input lb_state_e s);
    return (s != RUN);
  endfunction

endpackage

// File: rtl/line_ram.sv
// 1R1W synchronous RAM of one image row; a same-address read and write in
// one cycle return the word held before the write.
module line_ram #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 480,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/line_buffer_3row.sv
// Three-row line buffer presenting one vertical column per accepted pixel.
// Optional zero top border selected by macro LINEBUF_ZERO_PAD_EN.
module line_buffer_3row
  import imgproc_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int PIC_WIDTH  = PIC_WIDTH_DEF,
  parameter int PIC_HEIGHT = PIC_HEIGHT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3,
  output logic             valid_out
);

  localparam int COL_W = $clog2(PIC_WIDTH);
  localparam int ROW_W = $clog2(PIC_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(PIC_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(PIC_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

`ifdef LINEBUF_ZERO_PAD_EN
  localparam logic ZERO_PAD = 1'b1;
`else
  localparam logic ZERO_PAD = 1'b0;
`endif

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  lb_state_e        state_q, state_d;
  logic [WIDTH-1:0] dout3_q, dout3_d;
  logic             vout_q, vout_d;
  logic             zero1_q, zero1_d;
  logic             zero2_q, zero2_d;
  logic             apend_q, apend_d;
  logic [COL_W-1:0] acol_q, acol_d;

  logic             accept_s;
  logic             col_wrap_s;
  logic [WIDTH-1:0] a_rdata_s;
  logic [WIDTH-1:0] b_rdata_s;

  assign accept_s   = valid_in & ~rst;
  assign col_wrap_s = (col_q == COL_LAST);

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    state_d = state_q;
    if (accept_s) begin
      if (col_wrap_s) begin
        col_d = {COL_W{1'b0}};
        row_d = (row_q == ROW_LAST) ? {ROW_W{1'b0}} : row_q + ROW_ONE;
        case (state_q)
          FILL0:   state_d = FILL1;
          FILL1:   state_d = RUN;
          RUN:     state_d = (row_q == ROW_LAST) ? FILL0 : RUN;
          default: state_d = FILL0;
        endcase
      end else begin
        col_d = col_q + COL_ONE;
      end
    end else begin
      col_d   = col_q;
      row_d   = row_q;
      state_d = state_q;
    end
  end

  // zero1/zero2 mask the RAM read ports: cleared RAM output after reset, and the top border.
  always_comb begin
    dout3_d = dout3_q;
    vout_d  = 1'b0;
    zero1_d = zero1_q;
    zero2_d = zero2_q;
    apend_d = accept_s;
    acol_d  = acol_q;
    if (accept_s) begin
      dout3_d = din;
      vout_d  = (state_q == RUN) | ZERO_PAD;
      zero1_d = ZERO_PAD & is_fill(state_q);
      zero2_d = ZERO_PAD & (state_q == FILL0);
      acol_d  = col_q;
    end else begin
      dout3_d = dout3_q;
      acol_d  = acol_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= {COL_W{1'b0}};
      row_q   <= {ROW_W{1'b0}};
      state_q <= FILL0;
      dout3_q <= {WIDTH{1'b0}};
      vout_q  <= 1'b0;
      zero1_q <= 1'b1;
      zero2_q <= 1'b1;
      apend_q <= 1'b0;
      acol_q  <= {COL_W{1'b0}};
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      state_q <= state_d;
      dout3_q <= dout3_d;
      vout_q  <= vout_d;
      zero1_q <= zero1_d;
      zero2_q <= zero2_d;
      apend_q <= apend_d;
      acol_q  <= acol_d;
    end
  end

  line_ram #(.WIDTH(WIDTH), .DEPTH(PIC_WIDTH), .AW(COL_W)) u_ram_b (
    .clk     (clk),
    .re_i    (accept_s),
    .raddr_i (col_q),
    .rdata_o (b_rdata_s),
    .we_i    (accept_s),
    .waddr_i (col_q),
    .wdata_i (din)
  );

  // A takes the old B word one cycle later, once B's read register holds it.
  line_ram #(.WIDTH(WIDTH), .DEPTH(PIC_WIDTH), .AW(COL_W)) u_ram_a (
    .clk     (clk),
    .re_i    (accept_s),
    .raddr_i (col_q),
    .rdata_o (a_rdata_s),
    .we_i    (apend_q),
    .waddr_i (acol_q),
    .wdata_i (b_rdata_s)
  );

  assign dout1     = zero1_q ? {WIDTH{1'b0}} : a_rdata_s;
  assign dout2     = zero2_q ? {WIDTH{1'b0}} : b_rdata_s;
  assign dout3     = dout3_q;
  assign valid_out = vout_q;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Scoreboard bench for line_buffer_3row on a 4x4 frame with din = 10*row+col.
module tb_line_buffer_3row;
  import imgproc_pkg::*;

  localparam int W  = 16;
  localparam int PW = 4;
  localparam int PH = 4;
`ifdef LINEBUF_ZERO_PAD_EN
  localparam bit PAD         = 1'b1;
  localparam int PER_FRAME   = 16;
  localparam int MID_RST_CNT = 26;
`else
  localparam bit PAD         = 1'b0;
  localparam int PER_FRAME   = 8;
  localparam int MID_RST_CNT = 10;
`endif

  typedef struct {
    int d1;
    int d2;
    int d3;
    int cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in;
  logic [W-1:0] din;
  logic [W-1:0] dout1, dout2, dout3;
  logic         valid_out;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   pulses   = 0;
  int   base     = 0;
  int   exp_cnt  = 0;
  bit   chk_zero = 1'b0;
  bit   chk_state = 1'b0;
  bit   chk_end  = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  line_buffer_3row #(.WIDTH(W), .PIC_WIDTH(PW), .PIC_HEIGHT(PH)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .din       (din),
    .dout1     (dout1),
    .dout2     (dout2),
    .dout3     (dout3),
    .valid_out (valid_out)
  );

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: all comparisons happen here, on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_out === 1'b1) begin
        pulses++;
        chk("pulse_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("dout1", int'(dout1), e.d1);
          chk("dout2", int'(dout2), e.d2);
          chk("dout3", int'(dout3), e.d3);
          chk("latency", cyc, e.cyc);
        end
      end
      if (chk_zero) begin
        chk("rst_dout1", int'(dout1), 0);
        chk("rst_dout2", int'(dout2), 0);
        chk("rst_dout3", int'(dout3), 0);
        chk("rst_valid_out", int'(valid_out), 0);
      end
      if (chk_state) begin
        chk("state_after_frame", int'(dut.state_q), int'(FILL0));
      end
      if (chk_end) begin
        chk("pulse_count", pulses - base, exp_cnt);
        chk("queue_drained", exp_q.size(), 0);
      end
    end
  end

  task automatic send(input int r, input int c, input bit st);
    exp_t e;
    @(posedge clk); #1;
    chk_zero  = 1'b0;
    chk_end   = 1'b0;
    chk_state = st;
    rst       = 1'b0;
    valid_in  = 1'b1;
    din       = W'(10 * r + c);
    e.cyc = cyc + 1;
    e.d3  = 10 * r + c;
    if (r >= 2) begin
      e.d1 = 10 * (r - 2) + c;
      e.d2 = 10 * (r - 1) + c;
      exp_q.push_back(e);
    end else if (PAD) begin
      e.d1 = 0;
      e.d2 = (r == 1) ? c : 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      valid_in  = 1'b0;
      chk_zero  = 1'b0;
      chk_state = 1'b0;
      chk_end   = 1'b0;
    end
  endtask

  task automatic frame(input bit gaps, input bit st_first);
    for (int r = 0; r < PH; r++) begin
      for (int c = 0; c < PW; c++) begin
        send(r, c, st_first && r == 0 && c == 0);
        if (gaps) idle(1);
      end
    end
  endtask

  task automatic end_test(input int n);
    idle(3);
    @(posedge clk); #1;
    exp_cnt = n;
    chk_end = 1'b1;
    idle(1);
    base = pulses;
  endtask

  // One reset cycle with valid_in low, then check the cleared outputs.
  task automatic pulse_reset();
    @(posedge clk); #1;
    valid_in = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    chk_zero = 1'b1;
    idle(1);
  endtask

  initial begin
    rst = 1'b1;
    valid_in = 1'b0;
    din = '0;
    repeat (2) @(posedge clk);
    #1 chk_zero = 1'b1;
    @(posedge clk); #1;
    chk_zero = 1'b0;
    rst = 1'b0;
    idle(2);

    // continuous frame
    frame(1'b0, 1'b0);
    end_test(PER_FRAME);

    // valid_in toggling every cycle
    frame(1'b1, 1'b0);
    end_test(PER_FRAME);

    // two back-to-back frames, state checked once pixel 15 is taken
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b1);
    end_test(2 * PER_FRAME);

    // reset after pixel 9, then a fresh frame
    for (int i = 0; i < 10; i++) send(i / PW, i % PW, 1'b0);
    pulse_reset();
    frame(1'b0, 1'b0);
    end_test(MID_RST_CNT);

    // reset held with valid_in high: nothing advances
    @(posedge clk); #1;
    rst = 1'b1;
    valid_in = 1'b1;
    din = W'(55);
    repeat (3) begin
      @(posedge clk); #1;
      chk_zero = 1'b1;
    end
    frame(1'b0, 1'b0);
    end_test(PER_FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected end of test");
    $fatal(1);
  end

endmodule
